// File: rtl/shift_div8_pkg.sv
// Shared arithmetic datapath definitions.
// Control-state encoding and default operand width.
package shift_div8_pkg;

  localparam int ARITH_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arith_state_t;

endpackage

// File: rtl/shift_div8_div_step.sv
// One restoring-division iteration.
// Shift in the next dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   rem,
  input  logic         quo_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_nxt,
  output logic         qbit
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;

  always_comb begin
    shifted = {rem[N-1:0], quo_msb};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    qbit    = ~trial[N+1];
    rem_nxt = qbit ? trial[N:0] : shifted;
  end

  logic unused_rem_msb;
  assign unused_rem_msb = rem[N];

endmodule

// File: rtl/shift_div8.sv
// Sequential restoring divider, one quotient bit per falling edge.
// Shares the multiplier's falling-edge timing and mult_rst net.
module shift_div8
  import shift_div8_pkg::*;
#(
  parameter int N = ARITH_N
) (
  input  logic         clk,
  input  logic         mult_rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  arith_state_t state, state_n;

  logic [N-1:0]  quo_reg, quo_n;
  logic [N:0]    rem_reg, rem_n;
  logic [N-1:0]  div_reg, div_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dz_reg, dz_n;

  logic [N:0] rem_step;
  logic       qbit;

  div_step #(.N(N)) u_step (
    .rem     (rem_reg),
    .quo_msb (quo_reg[N-1]),
    .divisor (div_reg),
    .rem_nxt (rem_step),
    .qbit    (qbit)
  );

  always_ff @(negedge clk or posedge mult_rst) begin
    if (mult_rst) begin
      state   <= ST_IDLE;
      quo_reg <= '0;
      rem_reg <= '0;
      div_reg <= '0;
      cnt     <= '0;
      dz_reg  <= 1'b0;
    end else begin
      state   <= state_n;
      quo_reg <= quo_n;
      rem_reg <= rem_n;
      div_reg <= div_n;
      cnt     <= cnt_n;
      dz_reg  <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    quo_n   = quo_reg;
    rem_n   = rem_reg;
    div_n   = div_reg;
    cnt_n   = cnt;
    dz_n    = dz_reg;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          quo_n   = a;
          rem_n   = '0;
          div_n   = b;
          cnt_n   = '0;
          dz_n    = (b == '0);
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        quo_n = {quo_reg[N-2:0], qbit};
        rem_n = rem_step;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign q        = quo_reg;
  assign r        = rem_reg[N-1:0];
  assign busy     = (state == ST_BUSY);
  assign done     = (state == ST_DONE);
  assign div_zero = dz_reg;

endmodule
